multiexp_chunk_sequencer: RTL
=============================

Name: multiexp_chunk_sequencer

Overview:
Control-plane sequencer in front of the kernel's read/compute/write datapath (read master, adder/compute stage, write master, all started together). It accepts one host job (base address, total bytes) and splits it into fixed-size chunks. Per chunk it issues one start pulse with that chunk's offset and size, then waits for the datapath's done before issuing the next chunk. When all chunks complete it raises ap_done, so the datapath never sees a transfer larger than C_CHUNK_BYTES.

Parameters:
C_M_AXI_ADDR_WIDTH, 64, width of byte addresses.
C_XFER_SIZE_WIDTH, 32, width of byte counts.
C_CHUNK_BYTES, 4096, maximum bytes per datapath transfer. Must be a power of 2 and a multiple of 64.
C_CNT_WIDTH, 16, width of the completed-chunk counter.

Ports:
aclk  in  1  kernel clock; all logic in this domain.
areset  in  1  synchronous, active-high reset.
ap_start  in  1  job request; sampled only in IDLE.
ap_done  out  1  one-cycle pulse when the job completes.
ap_idle  out  1  high in IDLE.
ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  job base byte address.
ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  job total bytes.
dp_start  out  1  one-cycle datapath start pulse.
dp_addr_offset  out  C_M_AXI_ADDR_WIDTH  current chunk address; stable from dp_start until dp_done.
dp_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  current chunk bytes; stable from dp_start until dp_done.
dp_done  in  1  datapath completion pulse (the write master's done).
chunk_count  out  C_CNT_WIDTH  chunks completed in the current or last job.

Behaviour:
- Reset values: state=IDLE, ap_done=0, ap_idle=1, dp_start=0, dp_addr_offset=0, dp_xfer_size_in_bytes=0, chunk_count=0, internal remaining/next_addr=0.
- Reset mid-job: return to IDLE on the next edge. Any dp_done arriving afterwards is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On ap_start=1, latch next_addr=ctrl_addr_offset, remaining=ctrl_xfer_size_in_bytes, and clear chunk_count.
  - If remaining is nonzero, go to ISSUE; otherwise go to DONE.
- ISSUE (exactly 1 cycle):
  - dp_start=1.
  - dp_addr_offset=next_addr.
  - dp_xfer_size_in_bytes=min(remaining, C_CHUNK_BYTES).
  - Go to WAIT.
  - A dp_done seen in this cycle is ignored (stale).
- WAIT, on dp_done=1:
  - remaining -= dp_xfer_size_in_bytes; next_addr += dp_xfer_size_in_bytes; chunk_count += 1.
  - If the new remaining is 0, go to DONE; else go to ISSUE.
- DONE (1 cycle): ap_done=1, then go to IDLE.
- Registered outputs; latency:
  - ap_start at cycle N gives dp_start at N+1.
  - dp_done at M gives the next dp_start at M+1, or ap_done at M+1 for the final chunk.
  - Zero-size job: ap_done at N+1, no dp_start.
- ap_start outside IDLE is ignored (no queuing). ap_idle=0 from N+1 through the ap_done cycle, and 1 again the cycle after.
- Arithmetic:
  - min() compares at C_XFER_SIZE_WIDTH. The address add is at C_M_AXI_ADDR_WIDTH with the size zero-extended; wrap-around is modulo 2^C_M_AXI_ADDR_WIDTH with no error.
  - A non-multiple-of-64 remainder is passed unmodified in the final chunk.
  - chunk_count saturates at all-ones.
- The DONE cycle pulses ap_done unconditionally, including for a zero-size job.

Decomposition:
- Package multiexp_ctrl_pkg holds:
  - enum typedef seq_state_t {IDLE, ISSUE, WAIT, DONE};
  - localparam for the default chunk bytes;
  - a chunk-size function min_chunk(remaining).
- No sub-module. Single FSM plus datapath registers, roughly 150 lines of RTL.

Test Plan:
1. Base 0x1000, size 10000, chunk 4096 -> three dp_start pulses: (0x1000, 4096), (0x2000, 4096), (0x3000, 1808). ap_done occurs 1 cycle after the third dp_done; chunk_count=3.
2. Size 0 at cycle N -> ap_done at N+1, no dp_start, chunk_count=0.
3. Size 4096 exactly -> one dp_start (base, 4096), then ap_done. Also ap_start pulsed during WAIT -> ignored, no extra chunk.
4. areset asserted in WAIT of chunk 2, then dp_done -> all outputs at reset values, and a later ap_start with size 64 runs one clean chunk.
5. dp_done held high in the ISSUE cycle, then a real dp_done 5 cycles later -> only one remaining decrement; chunk offsets correct.
6. Base 0xFFFF_FFFF_FFFF_F000, size 8192 -> second chunk offset wraps to 0x0, no error. ap_idle pattern is 1,0...0,1 around the job.

Source files
------------

// File: rtl/multiexp_chunk_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// multiexp_ctrl_pkg
// Shared types and helpers for the multiexp chunk sequencer.
//   seq_state_t        : sequencer FSM states
//   C_CHUNK_BYTES_DFLT : default maximum bytes per datapath transfer
//   min_chunk()        : size of the next chunk given the bytes still to move
// -----------------------------------------------------------------------------
package multiexp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int unsigned C_CHUNK_BYTES_DFLT = 4096;

    // Operands arrive zero-extended to 64 bits, so the compare gives the same
    // answer as a compare at the caller's native count width.
    function automatic logic [63:0] min_chunk(input logic [63:0] remaining,
                                              input logic [63:0] chunk_bytes);
        return (remaining < chunk_bytes) ? remaining : chunk_bytes;
    endfunction

endpackage

// File: rtl/multiexp_chunk_sequencer_if.sv
// -----------------------------------------------------------------------------
// multiexp_chunk_sequencer_if
// Bundles the host control handshake and the datapath start/done handshake.
//   slave  modport : the sequencer (consumes ap_start/ctrl_*/dp_done)
//   master modport : the host + datapath side driving the sequencer
// -----------------------------------------------------------------------------
interface multiexp_chunk_sequencer_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_CNT_WIDTH        = 16
);
    logic                          ap_start;
    logic                          ap_done;
    logic                          ap_idle;
    logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset;
    logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes;
    logic                          dp_start;
    logic [C_M_AXI_ADDR_WIDTH-1:0] dp_addr_offset;
    logic [C_XFER_SIZE_WIDTH-1:0]  dp_xfer_size_in_bytes;
    logic                          dp_done;
    logic [C_CNT_WIDTH-1:0]        chunk_count;

    modport slave (
        input  ap_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, dp_done,
        output ap_done, ap_idle, dp_start, dp_addr_offset, dp_xfer_size_in_bytes,
               chunk_count
    );

    modport master (
        output ap_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, dp_done,
        input  ap_done, ap_idle, dp_start, dp_addr_offset, dp_xfer_size_in_bytes,
               chunk_count
    );
endinterface

// File: rtl/multiexp_chunk_sequencer.sv
// -----------------------------------------------------------------------------
// multiexp_chunk_sequencer
// Splits one host job (base address, total bytes) into transfers of at most
// C_CHUNK_BYTES, issuing one dp_start per chunk and waiting for dp_done before
// the next. ap_done pulses once the whole job has been retired.
// Ports:
//   aclk   : kernel clock
//   areset : synchronous, active-high reset
//   bus    : slave modport of multiexp_chunk_sequencer_if
//            (ap_start/ap_done/ap_idle, ctrl_*, dp_start/dp_*, dp_done,
//             chunk_count)
// All outputs are registered.
// -----------------------------------------------------------------------------
module multiexp_chunk_sequencer
    import multiexp_ctrl_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_CHUNK_BYTES      = C_CHUNK_BYTES_DFLT,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic                            aclk,
    input  logic                            areset,
    multiexp_chunk_sequencer_if.slave       bus
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int XW = C_XFER_SIZE_WIDTH;
    localparam int CW = C_CNT_WIDTH;
    localparam logic [XW-1:0] CHUNK = XW'(C_CHUNK_BYTES);

    seq_state_t    r_state;
    seq_state_t    w_state_nxt;
    logic          w_load;      // job accepted this cycle
    logic          w_retire;    // current chunk completed this cycle

    logic [AW-1:0] r_next_addr;
    logic [XW-1:0] r_remaining;
    logic [AW-1:0] w_addr_add;
    logic [XW-1:0] w_rem_sub;
    logic [AW-1:0] w_addr_nxt;
    logic [XW-1:0] w_rem_nxt;
    logic [XW-1:0] w_chunk;

    logic          r_ap_done;
    logic          r_ap_idle;
    logic          r_dp_start;
    logic [AW-1:0] r_dp_addr;
    logic [XW-1:0] r_dp_xfer;
    logic [CW-1:0] r_cnt;

    // Retiring a chunk consumes exactly the size that was issued for it;
    // the address add wraps silently at AW bits.
    assign w_rem_sub  = r_remaining - r_dp_xfer;
    assign w_addr_add = r_next_addr + AW'(r_dp_xfer);

    assign w_rem_nxt  = w_load   ? bus.ctrl_xfer_size_in_bytes :
                        w_retire ? w_rem_sub : r_remaining;
    assign w_addr_nxt = w_load   ? bus.ctrl_addr_offset :
                        w_retire ? w_addr_add : r_next_addr;

    assign w_chunk = XW'(min_chunk(64'(w_rem_nxt), 64'(CHUNK)));

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ap_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (bus.ctrl_xfer_size_in_bytes != '0) ? ISSUE : DONE;
                end
            end
            // dp_done during ISSUE belongs to nothing we issued; drop it.
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (bus.dp_done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = (w_rem_sub == '0) ? DONE : ISSUE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are decoded from the next state so they line up with the
    // state they describe while still coming straight from flops.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_remaining <= '0;
            r_next_addr <= '0;
            r_ap_done   <= 1'b0;
            r_ap_idle   <= 1'b1;
            r_dp_start  <= 1'b0;
            r_dp_addr   <= '0;
            r_dp_xfer   <= '0;
            r_cnt       <= '0;
        end else begin
            r_remaining <= w_rem_nxt;
            r_next_addr <= w_addr_nxt;
            r_ap_done   <= (w_state_nxt == DONE);
            r_ap_idle   <= (w_state_nxt == IDLE);
            r_dp_start  <= (w_state_nxt == ISSUE);
            // dp_addr/dp_xfer only move on entry to ISSUE, so they stay
            // stable through WAIT until the datapath reports done.
            if (w_state_nxt == ISSUE) begin
                r_dp_addr <= w_addr_nxt;
                r_dp_xfer <= w_chunk;
            end
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_retire && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.ap_done               = r_ap_done;
    assign bus.ap_idle               = r_ap_idle;
    assign bus.dp_start              = r_dp_start;
    assign bus.dp_addr_offset        = r_dp_addr;
    assign bus.dp_xfer_size_in_bytes = r_dp_xfer;
    assign bus.chunk_count           = r_cnt;

endmodule
